// File: rtl/rs_multi_cdb.sv
// Reservation station: holds DEPTH dispatched ops, snoops CDB_N result lanes, issues one ready op per cycle.
// Latency: dispatch with ready operands -> o_ex_valid two edges later; CDB wakeup -> o_ex_valid two edges later.
// Backpressure: o_disp_ready drops when full; issue register holds while o_ex_valid & !i_ex_ready.
// Build option: define RS_AGE_SELECT_EN for oldest-ready selection (age matrix); otherwise lowest-index ready.
module rs_multi_cdb #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int IMM_W  = 32,
  parameter int ADDR_W = 32,
  parameter int CDB_N  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_rdy,
  input  logic                      i_clear,
  input  logic                      i_disp_valid,
  output logic                      o_disp_ready,
  input  logic [TAG_W-1:0]          i_disp_dest,
  input  logic [TAG_W-1:0]          i_disp_q1,
  input  logic [TAG_W-1:0]          i_disp_q2,
  input  logic [DATA_W-1:0]         i_disp_v1,
  input  logic [DATA_W-1:0]         i_disp_v2,
  input  logic [OP_W-1:0]           i_disp_op,
  input  logic [IMM_W-1:0]          i_disp_imm,
  input  logic [ADDR_W-1:0]         i_disp_pc,
  input  logic [CDB_N*TAG_W-1:0]    i_cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   i_cdb_data,
  output logic                      o_ex_valid,
  input  logic                      i_ex_ready,
  output logic [OP_W-1:0]           o_ex_op,
  output logic [DATA_W-1:0]         o_ex_v1,
  output logic [DATA_W-1:0]         o_ex_v2,
  output logic [IMM_W-1:0]          o_ex_imm,
  output logic [ADDR_W-1:0]         o_ex_pc,
  output logic [TAG_W-1:0]          o_ex_dest,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry state
  logic [DEPTH-1:0]  r_busy;
  logic [TAG_W-1:0]  r_q1   [DEPTH];
  logic [TAG_W-1:0]  r_q2   [DEPTH];
  logic [DATA_W-1:0] r_v1   [DEPTH];
  logic [DATA_W-1:0] r_v2   [DEPTH];
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [IMM_W-1:0]  r_imm  [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [TAG_W-1:0]  r_dest [DEPTH];
  logic [CNT_W-1:0]  r_count;

  // Issue register
  logic              r_ex_valid;
  logic [OP_W-1:0]   r_ex_op;
  logic [DATA_W-1:0] r_ex_v1;
  logic [DATA_W-1:0] r_ex_v2;
  logic [IMM_W-1:0]  r_ex_imm;
  logic [ADDR_W-1:0] r_ex_pc;
  logic [TAG_W-1:0]  r_ex_dest;

  // Combinational control
  logic              w_wk1_hit [DEPTH];
  logic              w_wk2_hit [DEPTH];
  logic [DATA_W-1:0] w_wk1_dat [DEPTH];
  logic [DATA_W-1:0] w_wk2_dat [DEPTH];
  logic              w_byp1_hit, w_byp2_hit;
  logic [DATA_W-1:0] w_byp1_dat, w_byp2_dat;
  logic [DEPTH-1:0]  w_ready;
  logic [IDX_W-1:0]  w_free;
  logic [IDX_W-1:0]  w_sel;
  logic              w_issue;
  logic              w_disp;

  // Match a source tag against all lanes; scanning high-to-low lets the lowest lane win a repeated tag.
  function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] q);
    logic [DATA_W:0] res;
    res = '0;
    for (int k = CDB_N-1; k >= 0; k--) begin
      if (q != '0 && i_cdb_tag[k*TAG_W +: TAG_W] == q)
        res = {1'b1, i_cdb_data[k*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  assign o_disp_ready = (r_count != FULL_CNT);
  assign w_disp       = i_rdy & i_disp_valid & o_disp_ready;
  assign w_issue      = i_rdy & (~r_ex_valid | i_ex_ready) & (|w_ready);

  // Wakeup matches per entry, dispatch bypass matches, and ready vector from registered tags
  always_comb begin
    {w_byp1_hit, w_byp1_dat} = cdb_match(i_disp_q1);
    {w_byp2_hit, w_byp2_dat} = cdb_match(i_disp_q2);
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      {w_wk1_hit[i], w_wk1_dat[i]} = cdb_match(r_q1[i]);
      {w_wk2_hit[i], w_wk2_dat[i]} = cdb_match(r_q2[i]);
      w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
    end
  end

  // Lowest-index free slot for allocation (only used when a slot is free)
  always_comb begin
    w_free = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!r_busy[i]) w_free = IDX_W'(i);
  end

`ifdef RS_AGE_SELECT_EN
  // r_age[i][j] = 1 means entry i was allocated before entry j
  logic [DEPTH-1:0] r_age [DEPTH];

  // Oldest ready entry: ready and no other ready entry is older than it
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ready[i] && ((w_ready & ~r_age[i] & ~(DEPTH'(1) << i)) == '0))
        w_sel = IDX_W'(i);
    end
  end

  // Newly allocated slot becomes younger than every other slot
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (w_disp) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_age[w_free][j] <= 1'b0;
        if (IDX_W'(j) != w_free) r_age[j][w_free] <= 1'b1;
      end
    end
  end
`else
  // Lowest-index ready entry
  always_comb begin
    w_sel = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (w_ready[i]) w_sel = IDX_W'(i);
  end
`endif

  // Occupancy, busy bits and source tags: wakeup, allocate, free on issue
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_busy  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q1[i] <= '0;
        r_q2[i] <= '0;
      end
    end else if (i_rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && w_wk1_hit[i]) r_q1[i] <= '0;
        if (r_busy[i] && w_wk2_hit[i]) r_q2[i] <= '0;
      end
      if (w_issue) r_busy[w_sel] <= 1'b0;
      if (w_disp) begin
        r_busy[w_free] <= 1'b1;
        r_q1[w_free]   <= w_byp1_hit ? '0 : i_disp_q1;
        r_q2[w_free]   <= w_byp2_hit ? '0 : i_disp_q2;
      end
      case ({w_disp, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand values and payload; meaningful only while the slot is busy, so no reset needed
  always_ff @(posedge clk) begin
    if (i_rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && w_wk1_hit[i]) r_v1[i] <= w_wk1_dat[i];
        if (r_busy[i] && w_wk2_hit[i]) r_v2[i] <= w_wk2_dat[i];
      end
      if (w_disp) begin
        r_v1[w_free]   <= w_byp1_hit ? w_byp1_dat : i_disp_v1;
        r_v2[w_free]   <= w_byp2_hit ? w_byp2_dat : i_disp_v2;
        r_op[w_free]   <= i_disp_op;
        r_imm[w_free]  <= i_disp_imm;
        r_pc[w_free]   <= i_disp_pc;
        r_dest[w_free] <= i_disp_dest;
      end
    end
  end

  // Issue register: load selected entry when empty or draining, otherwise hold
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_v1    <= '0;
      r_ex_v2    <= '0;
      r_ex_imm   <= '0;
      r_ex_pc    <= '0;
      r_ex_dest  <= '0;
    end else if (i_rdy) begin
      if (w_issue) begin
        r_ex_valid <= 1'b1;
        r_ex_op    <= r_op[w_sel];
        r_ex_v1    <= r_v1[w_sel];
        r_ex_v2    <= r_v2[w_sel];
        r_ex_imm   <= r_imm[w_sel];
        r_ex_pc    <= r_pc[w_sel];
        r_ex_dest  <= r_dest[w_sel];
      end else if (i_ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign o_ex_valid = r_ex_valid;
  assign o_ex_op    = r_ex_op;
  assign o_ex_v1    = r_ex_v1;
  assign o_ex_v2    = r_ex_v2;
  assign o_ex_imm   = r_ex_imm;
  assign o_ex_pc    = r_ex_pc;
  assign o_ex_dest  = r_ex_dest;
  assign o_count    = r_count;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: scoreboard of expected issued ops, popped on each EX handshake.
// Inputs change 1ns after the rising edge; the handshake monitor samples on the falling edge.
// Issue order in the age test depends on RS_AGE_SELECT_EN, mirrored here.
module tb_rs_multi_cdb;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, disp_valid, disp_ready;
  logic [3:0]  dest, q1, q2;
  logic [31:0] v1, v2, imm, pc;
  logic [5:0]  op;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        ex_valid, ex_ready;
  logic [5:0]  ex_op;
  logic [31:0] ex_v1, ex_v2, ex_imm, ex_pc;
  logic [3:0]  ex_dest;
  logic [4:0]  count;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_xfer = 0;

  rs_multi_cdb dut (
    .clk(clk), .rst(rst), .i_rdy(rdy), .i_clear(clear),
    .i_disp_valid(disp_valid), .o_disp_ready(disp_ready),
    .i_disp_dest(dest), .i_disp_q1(q1), .i_disp_q2(q2),
    .i_disp_v1(v1), .i_disp_v2(v2), .i_disp_op(op), .i_disp_imm(imm), .i_disp_pc(pc),
    .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
    .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
    .o_ex_op(ex_op), .o_ex_v1(ex_v1), .o_ex_v2(ex_v2), .o_ex_imm(ex_imm),
    .o_ex_pc(ex_pc), .o_ex_dest(ex_dest), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [5:0] o, input logic [3:0] d,
                              input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.op   = o;
    e.v1   = a;
    e.v2   = b;
    e.imm  = 32'h1000 + {26'h0, o};
    e.pc   = 32'h400 + {24'h0, o, 2'b00};
    e.dest = d;
    return e;
  endfunction

  // Present one op for a single edge; caller drives cdb lanes around it if needed
  task automatic disp(input logic [5:0] o, input logic [3:0] d, input logic [3:0] a1,
                      input logic [3:0] a2, input logic [31:0] b1, input logic [31:0] b2);
    op   = o;  dest = d;  q1 = a1;  q2 = a2;  v1 = b1;  v2 = b2;
    imm  = 32'h1000 + {26'h0, o};
    pc   = 32'h400 + {24'h0, o, 2'b00};
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic cdb_idle();
    cdb_tag  = '0;
    cdb_data = '0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!ex_valid && n < budget) begin
      tick();
      n++;
    end
    if (!ex_valid) chk(tag, 256'(0), 256'(1));
  endtask

  // Scoreboard: every EX handshake must match the oldest expected op
  always @(negedge clk) begin
    if (!rst && !clear && rdy && ex_valid && ex_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 256'(1), 256'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ex_v1",   256'(ex_v1),   256'(e.v1));
        chk("ex_v2",   256'(ex_v2),   256'(e.v2));
        chk("ex_dest", 256'(ex_dest), 256'(e.dest));
        chk("ex_misc", 256'({ex_op, ex_imm, ex_pc}), 256'({e.op, e.imm, e.pc}));
        n_xfer++;
      end
    end
  end

  initial begin
    int n0;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; disp_valid = 1'b0; ex_ready = 1'b0;
    op = '0; dest = '0; q1 = '0; q2 = '0; v1 = '0; v2 = '0; imm = '0; pc = '0;
    cdb_idle();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ex_valid",   256'(ex_valid),   256'(0));
    chk("rst_disp_ready", 256'(disp_ready), 256'(1));
    chk("rst_count",      256'(count),      256'(0));
    chk("rst_ex_payload", 256'({ex_op, ex_v1, ex_v2, ex_imm, ex_pc, ex_dest}), 256'(0));

    // Ready operands: one edge into the RS, one edge into the issue register
    ex_ready = 1'b1;
    sb.push_back(mk(6'd3, 4'd2, 32'd5, 32'd7));
    disp(6'd3, 4'd2, 4'd0, 4'd0, 32'd5, 32'd7);
    chk("t2_count_after_disp", 256'(count),    256'(1));
    chk("t2_not_yet_valid",    256'(ex_valid), 256'(0));
    tick();
    chk("t2_ex_valid", 256'(ex_valid), 256'(1));
    chk("t2_count0",   256'(count),    256'(0));
    tick();
    chk("t2_drained",  256'(ex_valid), 256'(0));

    // Wakeup on lane 1
    sb.push_back(mk(6'd4, 4'd3, 32'hAB, 32'h33));
    disp(6'd4, 4'd3, 4'd4, 4'd0, 32'hDEAD, 32'h33);
    tick();
    chk("t3_waiting", 256'(ex_valid), 256'(0));
    cdb_tag = {4'd4, 4'd0}; cdb_data = {32'hAB, 32'h0};
    tick();
    cdb_idle();
    chk("t3_wake_edge", 256'(ex_valid), 256'(0));
    tick();
    chk("t3_ex_valid", 256'(ex_valid), 256'(1));
    tick();

    // Dispatch-time bypass from both lanes
    sb.push_back(mk(6'd5, 4'd8, 32'h11, 32'h22));
    cdb_tag = {4'd7, 4'd6}; cdb_data = {32'h22, 32'h11};
    disp(6'd5, 4'd8, 4'd6, 4'd7, 32'hBAD1, 32'hBAD2);
    cdb_idle();
    chk("t4_not_yet_valid", 256'(ex_valid), 256'(0));
    tick();
    chk("t4_ex_valid", 256'(ex_valid), 256'(1));
    tick();

    // Fill, stall EX, then drain back-to-back
    ex_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(mk(6'(i + 10), 4'(i), 32'h99, 32'(i * 3)));
      disp(6'(i + 10), 4'(i), 4'd9, 4'd0, 32'h0, 32'(i * 3));
    end
    chk("t5_full_count", 256'(count),      256'(16));
    chk("t5_disp_ready", 256'(disp_ready), 256'(0));
    disp(6'd63, 4'd15, 4'd0, 4'd0, 32'h1, 32'h1);
    chk("t5_extra_ignored", 256'(count), 256'(16));
    chk("t5_no_issue_yet",  256'(ex_valid), 256'(0));
    cdb_tag = {4'd0, 4'd9}; cdb_data = {32'h0, 32'h99};
    tick();
    cdb_idle();
    tick();
    chk("t5_loaded",       256'(ex_valid), 256'(1));
    chk("t5_count15",      256'(count),    256'(15));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_hold_valid", 256'(ex_valid), 256'(1));
      if (sb.size() > 0) begin
        chk("t5_hold_dest", 256'(ex_dest), 256'(sb[0].dest));
        chk("t5_hold_v",    256'({ex_op, ex_v1, ex_v2}), 256'({sb[0].op, sb[0].v1, sb[0].v2}));
      end else begin
        chk("t5_sb_empty", 256'(0), 256'(1));
      end
    end
    ex_ready = 1'b1;
    n0 = n_xfer;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("t5_back_to_back", 256'(ex_valid), 256'(1));
    end
    tick();
    chk("t5_xfers",    256'(n_xfer - n0), 256'(16));
    chk("t5_count0",   256'(count),       256'(0));
    chk("t5_ex_empty", 256'(ex_valid),    256'(0));

    // Selection order: A in slot 2, later B in slot 1, both woken together
    ex_ready = 1'b0;
    disp(6'd20, 4'd9, 4'd10, 4'd0, 32'h0, 32'h1);    // P0 slot 0, never woken
    disp(6'd21, 4'd1, 4'd11, 4'd0, 32'h0, 32'h2);    // P1 slot 1
    disp(6'd22, 4'd5, 4'd12, 4'd0, 32'h0, 32'hA);    // A slot 2
    cdb_tag = {4'd0, 4'd11}; cdb_data = {32'h0, 32'h111};
    tick();
    cdb_idle();
    tick();                                            // P1 into issue register, slot 1 freed
    chk("t6_p1_loaded", 256'(ex_valid), 256'(1));
    disp(6'd23, 4'd6, 4'd12, 4'd0, 32'h0, 32'hB);    // B slot 1
    cdb_tag = {4'd12, 4'd0}; cdb_data = {32'h222, 32'h0};
    tick();
    cdb_idle();
    sb.push_back(mk(6'd21, 4'd1, 32'h111, 32'h2));
`ifdef RS_AGE_SELECT_EN
    sb.push_back(mk(6'd22, 4'd5, 32'h222, 32'hA));
    sb.push_back(mk(6'd23, 4'd6, 32'h222, 32'hB));
`else
    sb.push_back(mk(6'd23, 4'd6, 32'h222, 32'hB));
    sb.push_back(mk(6'd22, 4'd5, 32'h222, 32'hA));
`endif
    chk("t6_count3", 256'(count), 256'(3));
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    chk("t6_second_valid", 256'(ex_valid), 256'(1));
    if (sb.size() > 0) chk("t6_order_dest", 256'(ex_dest), 256'(sb[0].dest));
    else               chk("t6_sb_empty", 256'(0), 256'(1));
    chk("t6_count2", 256'(count), 256'(2));

    // Clear with an op held in the issue register
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
    chk("t6_clear_valid", 256'(ex_valid),   256'(0));
    chk("t6_clear_count", 256'(count),      256'(0));
    chk("t6_clear_ready", 256'(disp_ready), 256'(1));

    // Normal operation resumes after clear
    ex_ready = 1'b1;
    sb.push_back(mk(6'd30, 4'd7, 32'h55, 32'h66));
    disp(6'd30, 4'd7, 4'd0, 4'd0, 32'h55, 32'h66);
    wait_valid("t7_timeout", 10);
    tick();
    chk("sb_drained", 256'(sb.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
